// File: rtl/crc_32_req_sequencer.sv
// Round-robin request sequencer in front of the multi-request CRC-32 core.
// Keeps a running CRC per lane across multi-beat packets, seeds on SOP,
// inverts on EOP and presents finished CRCs on a per-lane valid/ready port.
module crc_32_req_sequencer #(
    parameter int unsigned SIMPLE         = 0,
    parameter int unsigned REQ_COUNT      = 16,
    parameter int unsigned INST_COUNT     = 4,
    parameter int unsigned PARALLEL_DEPTH = 4
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic [REQ_COUNT*PARALLEL_DEPTH-1:0]    IN_VALID,
    input  logic [REQ_COUNT*PARALLEL_DEPTH*48-1:0] IN_DATA,
    input  logic [REQ_COUNT-1:0]                   IN_SOP,
    input  logic [REQ_COUNT-1:0]                   IN_EOP,
    output logic [REQ_COUNT-1:0]                   IN_READY,
    output logic [REQ_COUNT*32-1:0]                CRC_IN,
    output logic [REQ_COUNT*PARALLEL_DEPTH-1:0]    VALID,
    output logic [REQ_COUNT*PARALLEL_DEPTH*48-1:0] DATA,
    input  logic [REQ_COUNT*32-1:0]                CRC_OUT,
    output logic [REQ_COUNT-1:0]                   RES_VALID,
    output logic [REQ_COUNT*32-1:0]                RES_CRC,
    input  logic [REQ_COUNT-1:0]                   RES_READY,
    output logic [REQ_COUNT-1:0]                   ERR
);

    localparam int unsigned PD    = PARALLEL_DEPTH;
    localparam int unsigned PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;
    localparam int unsigned IDX_W = PTR_W + 1;
    localparam logic [31:0] SEED  = 32'hFFFF_FFFF;

    logic [REQ_COUNT-1:0]    req;
    logic [REQ_COUNT-1:0]    elig;
    logic [REQ_COUNT-1:0]    grant;
    logic [PTR_W-1:0]        ptr_q;
    logic [PTR_W-1:0]        ptr_d;
    logic [PTR_W-1:0]        last_idx;
    logic                    any_grant;
    logic [IDX_W-1:0]        scan_idx;
    logic [IDX_W-1:0]        scan_cnt;
    logic [IDX_W-1:0]        ptr_nxt;

    logic [REQ_COUNT*32-1:0] state_q;
    logic [REQ_COUNT*32-1:0] state_d;
    logic [REQ_COUNT*32-1:0] res_crc_q;
    logic [REQ_COUNT*32-1:0] res_crc_d;
    logic [REQ_COUNT-1:0]    busy_q;
    logic [REQ_COUNT-1:0]    busy_d;
    logic [REQ_COUNT-1:0]    res_valid_q;
    logic [REQ_COUNT-1:0]    res_valid_d;
    logic [REQ_COUNT-1:0]    err_q;
    logic [REQ_COUNT-1:0]    err_d;

    // A lane requests when its beat carries at least one valid word.
    always_comb begin
        req = '0;
        for (int i = 0; i < int'(REQ_COUNT); i++) begin
            req[i] = |IN_VALID[i*PD +: PD];
        end
    end

    // A lane may only advance when its result slot is empty or draining.
    assign elig = req & (~res_valid_q | RES_READY);

    // Grant up to INST_COUNT eligible lanes, scanning from the pointer with wrap.
    always_comb begin
        grant     = '0;
        ptr_d     = ptr_q;
        last_idx  = ptr_q;
        any_grant = 1'b0;
        scan_idx  = '0;
        scan_cnt  = '0;
        ptr_nxt   = '0;
        if (SIMPLE != 0) begin
            grant = elig;
        end else begin
            for (int k = 0; k < int'(REQ_COUNT); k++) begin
                scan_idx = IDX_W'(ptr_q) + IDX_W'(k);
                if (scan_idx >= IDX_W'(REQ_COUNT)) begin
                    scan_idx = scan_idx - IDX_W'(REQ_COUNT);
                end
                if (elig[scan_idx[PTR_W-1:0]] && (scan_cnt < IDX_W'(INST_COUNT))) begin
                    grant[scan_idx[PTR_W-1:0]] = 1'b1;
                    scan_cnt  = scan_cnt + IDX_W'(1);
                    last_idx  = scan_idx[PTR_W-1:0];
                    any_grant = 1'b1;
                end
            end
            if (any_grant) begin
                ptr_nxt = IDX_W'(last_idx) + IDX_W'(1);
                if (ptr_nxt >= IDX_W'(REQ_COUNT)) begin
                    ptr_nxt = '0;
                end
                ptr_d = ptr_nxt[PTR_W-1:0];
            end
        end
    end

    // Core drive: mask valids to granted lanes, seed CRC on SOP.
    always_comb begin
        VALID  = '0;
        CRC_IN = '0;
        for (int i = 0; i < int'(REQ_COUNT); i++) begin
            if (grant[i]) begin
                VALID[i*PD +: PD] = IN_VALID[i*PD +: PD];
            end
            CRC_IN[i*32 +: 32] = IN_SOP[i] ? SEED : state_q[i*32 +: 32];
        end
    end

    assign DATA     = IN_DATA;
    assign IN_READY = grant;

    // Per-lane packet tracking and result capture for accepted beats.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        res_crc_d   = res_crc_q;
        res_valid_d = res_valid_q & ~RES_READY;
        err_d       = '0;
        for (int i = 0; i < int'(REQ_COUNT); i++) begin
            if (grant[i]) begin
                // SOP on a busy lane restarts; a continuation on an idle lane is dropped.
                if ((IN_SOP[i] && busy_q[i]) || (!IN_SOP[i] && !busy_q[i])) begin
                    err_d[i] = 1'b1;
                end
                if (IN_EOP[i] && (IN_SOP[i] || busy_q[i])) begin
                    res_crc_d[i*32 +: 32] = ~CRC_OUT[i*32 +: 32];
                    res_valid_d[i]        = 1'b1;
                    busy_d[i]             = 1'b0;
                    state_d[i*32 +: 32]   = SEED;
                end else if (IN_SOP[i]) begin
                    state_d[i*32 +: 32] = CRC_OUT[i*32 +: 32];
                    busy_d[i]           = 1'b1;
                end else if (busy_q[i]) begin
                    state_d[i*32 +: 32] = CRC_OUT[i*32 +: 32];
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ptr_q       <= '0;
            state_q     <= {REQ_COUNT{SEED}};
            busy_q      <= '0;
            res_valid_q <= '0;
            res_crc_q   <= '0;
            err_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            state_q     <= state_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
            err_q       <= err_d;
        end
    end

    assign RES_VALID = res_valid_q;
    assign RES_CRC   = res_crc_q;
    assign ERR       = err_q;

endmodule

// File: doc/crc_32_req_sequencer.md
Name: crc_32_req_sequencer

Overview:
- Upstream companion to the multi-request CRC-32 combinational core. Drives the core's CRC_IN/VALID/DATA and captures its CRC_OUT.
- Holds running CRC-32 state per request lane across multi-beat packets: seeds 0xFFFFFFFF on SOP, applies final inversion on EOP, presents results on a per-lane valid/ready port.
- Arbitrates lanes round-robin so no more than INST_COUNT lanes reach the core in one cycle. This stops the core's fixed lowest-index selection from starving lanes or dropping them.

Parameters:
- SIMPLE, 0, must match the core's setting. 1 = core has one engine per lane, so arbitration is bypassed and all ready lanes are granted.
- REQ_COUNT, 16, number of request lanes.
- INST_COUNT, 4, maximum lanes granted per cycle when SIMPLE=0. Range 1..REQ_COUNT.
- PARALLEL_DEPTH, 4, 48-bit words per lane per beat.

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- IN_VALID  in  REQ_COUNT*PARALLEL_DEPTH  per-lane word valids; lane i uses bits [i*PD+:PD], contiguous from bit 0.
- IN_DATA  in  REQ_COUNT*PARALLEL_DEPTH*48  per-lane beat data, same lane slicing.
- IN_SOP  in  REQ_COUNT  beat is first of packet.
- IN_EOP  in  REQ_COUNT  beat is last of packet; SOP and EOP may both be set (single-beat packet).
- IN_READY  out  REQ_COUNT  lane beat accepted this cycle.
- CRC_IN  out  REQ_COUNT*32  to core.
- VALID  out  REQ_COUNT*PARALLEL_DEPTH  to core; masked to granted lanes.
- DATA  out  REQ_COUNT*PARALLEL_DEPTH*48  to core; IN_DATA passed through.
- CRC_OUT  in  REQ_COUNT*32  from core, same cycle.
- RES_VALID  out  REQ_COUNT  per-lane finished CRC available.
- RES_CRC  out  REQ_COUNT*32  finished CRC (inverted), lane-sliced.
- RES_READY  in  REQ_COUNT  consumer takes result.
- ERR  out  REQ_COUNT  one-cycle pulse per protocol violation.

Behaviour:
- Definitions:
  - req[i] = |IN_VALID lane i. Beats with no valid words are ignored, including their SOP and EOP.
  - free[i] = ~RES_VALID[i] | RES_READY[i].
  - elig[i] = req[i] & free[i].
- Grant:
  - SIMPLE=1: grant = elig.
  - SIMPLE=0: scan lanes starting at pointer PTR with wrap-around. Grant the first INST_COUNT eligible lanes.
  - When any lane is granted, PTR becomes (index of last granted lane + 1) mod REQ_COUNT. Otherwise PTR holds.
- Handshake:
  - IN_READY[i] = grant[i]. Ready is combinational from valid; valid must not depend on ready.
  - Accept = grant[i]. Ungranted lanes must hold their beat.
- Core drive:
  - VALID lane i = IN_VALID lane i when grant[i], else 0.
  - CRC_IN[i] = 0xFFFFFFFF if IN_SOP[i], else STATE[i].
- State per lane:
  - STATE[31:0] holds the running CRC.
  - BUSY is set while a packet is in progress.
- On accepted beat:
  - SOP & ~EOP: STATE <= CRC_OUT[i], BUSY <= 1.
  - ~SOP & ~EOP & BUSY: STATE <= CRC_OUT[i].
  - EOP & (SOP | BUSY): RES_CRC[i] <= ~CRC_OUT[i], RES_VALID[i] <= 1, BUSY <= 0, STATE <= 0xFFFFFFFF.
  - SOP while BUSY: restart from seed; in-flight packet discarded; ERR pulse.
  - ~SOP while ~BUSY: beat consumed, no state change, no result, ERR pulse.
- Result port:
  - RES_VALID clears when RES_READY is high and no new EOP completes that cycle.
  - If an EOP completes in the same cycle a result drains, RES_VALID stays 1 and RES_CRC takes the new value.
  - RES_CRC is stable while RES_VALID is set and not drained.
- Latency: result visible on RES_VALID the cycle after its EOP beat is accepted.
- Reset (RST_N low at edge):
  - STATE = 0xFFFFFFFF, BUSY = 0, RES_VALID = 0, RES_CRC = 0, ERR = 0, PTR = 0.
  - Reset mid-packet discards all lanes.
  - The combinational outputs (IN_READY, VALID, CRC_IN) still follow inputs, so the upstream must not drive valids during reset.
- Widths: no arithmetic beyond the pointer, which wraps modulo REQ_COUNT. CRC_IN/CRC_OUT lane i is bits [i*32+:32].

Test Plan:
- Single-beat packet, lane 0: SOP=EOP=1, one word 48'h0, RES_READY=1.
  - Required: CRC_IN[0]=FFFFFFFF, result equals the software CRC-32 model of 6 zero bytes one cycle later, RES_VALID pulses once.
- Three-beat packet, lane 5, PD=4:
  - Required: STATE chains across beats, final RES_CRC matches the model over 72 bytes, IN_READY high all beats.
- All 16 lanes request every cycle, INST_COUNT=4:
  - Required: grants 0-3, 4-7, 8-11, 12-15, 0-3 in consecutive cycles; never more than 4 VALID lanes non-zero.
- Backpressure, lane 2: RES_READY=0 holding a result, new single-beat packet offered.
  - Required: IN_READY[2]=0 until RES_READY pulses. Same-cycle drain plus new EOP keeps RES_VALID=1 with the new CRC.
- Protocol errors:
  - Beat without SOP on idle lane 1 -> ERR[1] pulse, no result.
  - SOP mid-packet on lane 1 -> ERR[1] pulse, result equals CRC of the second packet only.
- Reset mid-packet on lane 3 after 1 of 2 beats:
  - Required: after reset, RES_VALID=0, PTR=0. A fresh packet produces the correct CRC.
